// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared cpu package: fetch FSM states, NOP word, cuOP opcodes
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'b00,
        FETCH_REQ  = 2'b01,
        FETCH_EXEC = 2'b10,
        FETCH_ERR  = 2'b11
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] CUOP_LUI    = 7'b0110111;
    localparam logic [6:0] CUOP_AUIPC  = 7'b0010111;
    localparam logic [6:0] CUOP_JAL    = 7'b1101111;
    localparam logic [6:0] CUOP_JALR   = 7'b1100111;
    localparam logic [6:0] CUOP_BRANCH = 7'b1100011;
    localparam logic [6:0] CUOP_LOAD   = 7'b0000011;
    localparam logic [6:0] CUOP_STORE  = 7'b0100011;
    localparam logic [6:0] CUOP_ITYPE  = 7'b0010011;
    localparam logic [6:0] CUOP_RTYPE  = 7'b0110011;
    localparam logic [6:0] CUOP_SYSTEM = 7'b1110011;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

    // Timeout counter never narrower than 8 bits, wide enough to hold TIMEOUT.
    function automatic int timeout_width(input int unsigned timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch FSM: request, hold under stall, sticky fault
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter logic [31:0] NOP     = NOP_INSTR
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic [31:0] PCaddr,
    input  logic        stall,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    output logic [31:0] instr,
    output logic        iready,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    localparam int TW = timeout_width(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 32'd1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   instr_q, instr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   count_q, count_d;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH_IDLE;
            instr_q <= NOP;
            tmo_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        tmo_d     = tmo_q;
        count_d   = count_q;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        iready    = 1'b0;
        instr     = NOP;
        fetch_err = 1'b0;

        unique case (state_q)
            FETCH_IDLE: begin
                state_d = FETCH_REQ;
                tmo_d   = '0;
            end
            FETCH_REQ: begin
                // A misaligned PC never reaches memory, so any ack is ignored.
                if (!is_word_aligned(PCaddr[1:0])) begin
                    state_d = FETCH_ERR;
                end else begin
                    mem_ren  = 1'b1;
                    mem_addr = PCaddr;
                    if (mem_ack) begin
                        instr_d = mem_rdata;
                        state_d = FETCH_EXEC;
                    end else if (tmo_q == TMO_LAST) begin
                        state_d = FETCH_ERR;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            FETCH_EXEC: begin
                instr = instr_q;
                if (!stall) begin
                    iready  = 1'b1;
                    count_d = count_q + 32'd1;
                    state_d = FETCH_REQ;
                    tmo_d   = '0;
                end
            end
            FETCH_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench with a transaction-level fetch model checked every cycle
module tb_instr_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam int          TMO   = 255;

    logic        clk;
    logic        nRST, nRST4;
    logic [31:0] PCaddr;
    logic        stall, mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_ren, iready, fetch_err;
    logic [31:0] mem_addr, instr, instr_count;
    logic        mem_ren4, iready4, fetch_err4;
    logic [31:0] mem_addr4, instr4, instr_count4;

    instr_fetch u_dut (
        .clk(clk), .nRST(nRST), .PCaddr(PCaddr), .stall(stall),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .instr(instr), .iready(iready),
        .fetch_err(fetch_err), .instr_count(instr_count)
    );

    instr_fetch #(.TIMEOUT(4)) u_dut4 (
        .clk(clk), .nRST(nRST4), .PCaddr(PCaddr), .stall(stall),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_ren(mem_ren4),
        .mem_addr(mem_addr4), .instr(instr4), .iready(iready4),
        .fetch_err(fetch_err4), .instr_count(instr_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit force_active = 1'b0;

    // Model: "booting" (first cycle after reset), "fault", "holding a word", else fetching.
    bit          m_boot  = 1'b1;
    bit          m_fault = 1'b0;
    bit          m_held  = 1'b0;
    logic [31:0] m_word  = 32'h0;
    logic [31:0] m_count = 32'h0;
    int          m_wait  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic model_check();
        logic        e_ren, e_rdy, e_err;
        logic [31:0] e_addr, e_instr, e_count;
        e_ren = 1'b0; e_rdy = 1'b0; e_err = 1'b0;
        e_addr = 32'h0; e_instr = NOP_W;
        if (force_active) m_count = 32'hFFFF_FFFF;
        if (!nRST) begin
            m_boot = 1'b1; m_fault = 1'b0; m_held = 1'b0; m_wait = 0; m_count = 32'h0;
        end
        e_count = m_count;
        if (!nRST) begin
        end else if (m_fault) begin
            e_err = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
            m_wait = 0;
        end else if (m_held) begin
            e_instr = m_word;
            if (!stall) begin
                e_rdy   = 1'b1;
                m_count = m_count + 32'd1;
                m_held  = 1'b0;
                m_wait  = 0;
            end
        end else if (PCaddr[1:0] != 2'b00) begin
            m_fault = 1'b1;
        end else begin
            e_ren  = 1'b1;
            e_addr = PCaddr;
            if (mem_ack) begin
                m_word = mem_rdata;
                m_held = 1'b1;
            end else if (m_wait == TMO - 1) begin
                m_fault = 1'b1;
            end else begin
                m_wait++;
            end
        end
        check1 ("model_mem_ren",     mem_ren,     e_ren);
        check32("model_mem_addr",    mem_addr,    e_addr);
        check1 ("model_iready",      iready,      e_rdy);
        check32("model_instr",       instr,       e_instr);
        check1 ("model_fetch_err",   fetch_err,   e_err);
        check32("model_instr_count", instr_count, e_count);
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            sample();
            tick();
        end
    endtask

    initial begin
        nRST = 1'b0; nRST4 = 1'b0; PCaddr = 32'h100; stall = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        tick();

        sample();
        check1 ("rst_mem_ren", mem_ren, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check1 ("rst_iready", iready, 1'b0);
        check32("rst_instr", instr, NOP_W);
        check1 ("rst_fetch_err", fetch_err, 1'b0);
        check32("rst_count", instr_count, 32'h0);
        tick();

        // First fetch: IDLE, REQ with immediate ack, EXEC
        PCaddr = 32'h0; mem_rdata = 32'h0050_0093; nRST = 1'b1;
        sample(); check1("c1_idle_no_ren", mem_ren, 1'b0); tick();
        mem_ack = 1'b1;
        sample(); check1("c2_ren", mem_ren, 1'b1); check32("c2_addr", mem_addr, 32'h0); tick();
        mem_ack = 1'b0; mem_rdata = 32'h1111_1111;
        sample(); check32("c3_instr", instr, 32'h0050_0093); check1("c3_iready", iready, 1'b1); tick();

        // Ack delayed five cycles
        PCaddr = 32'h4; mem_rdata = 32'h00A0_0113;
        sample(); check32("c4_count", instr_count, 32'd1); check1("c4_no_b2b", iready, 1'b0); tick();
        for (int i = 1; i < 5; i++) begin
            sample();
            check1("dly_ren", mem_ren, 1'b1); check32("dly_addr", mem_addr, 32'h4);
            check1("dly_iready", iready, 1'b0);
            tick();
        end
        mem_ack = 1'b1;
        sample(); check1("dly_ack_ren", mem_ren, 1'b1); tick();
        mem_ack = 1'b0;
        sample(); check32("dly_instr", instr, 32'h00A0_0113); check1("dly_iready1", iready, 1'b1); tick();

        // Stall holds EXEC for three cycles
        PCaddr = 32'h8; mem_ack = 1'b1; mem_rdata = 32'h0020_8193;
        sample(); tick();
        mem_ack = 1'b0; stall = 1'b1; mem_rdata = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            sample();
            check1("stall_iready", iready, 1'b0); check32("stall_instr", instr, 32'h0020_8193);
            tick();
        end
        stall = 1'b0;
        sample(); check1("stall_drop_iready", iready, 1'b1); tick();

        // Minimum two-cycle fetch period
        PCaddr = 32'hC; mem_ack = 1'b1; mem_rdata = 32'h4000_0033;
        sample(); check1("b2b_req_ren", mem_ren, 1'b1); tick();
        sample(); check1("b2b_rdy_a", iready, 1'b1); check32("b2b_instr", instr, 32'h4000_0033); tick();
        sample(); check1("b2b_gap", iready, 1'b0); tick();
        sample(); check1("b2b_rdy_b", iready, 1'b1); tick();
        mem_ack = 1'b0;

        // Ack on the last permitted REQ cycle still succeeds
        PCaddr = 32'h10; mem_rdata = 32'h00C0_0213;
        sample(); check32("count5", instr_count, 32'd5); tick();
        cyc(253);
        mem_ack = 1'b1;
        sample(); check1("tmo_edge_ren", mem_ren, 1'b1); tick();
        mem_ack = 1'b0;
        sample();
        check1("tmo_edge_iready", iready, 1'b1); check32("tmo_edge_instr", instr, 32'h00C0_0213);
        check1("tmo_edge_no_err", fetch_err, 1'b0);
        tick();

        // Full timeout with default TIMEOUT
        PCaddr = 32'h14;
        cyc(254);
        sample(); check1("tmo255_last_ren", mem_ren, 1'b1); tick();
        sample(); check1("tmo255_err", fetch_err, 1'b1); check1("tmo255_ren", mem_ren, 1'b0); tick();
        mem_ack = 1'b1;
        cyc(2);
        mem_ack = 1'b0;

        // Misaligned PC faults without a request
        nRST = 1'b0;
        sample(); check1("err_cleared_by_rst", fetch_err, 1'b0); tick();
        PCaddr = 32'h2; mem_ack = 1'b1; nRST = 1'b1;
        sample(); tick();
        sample(); check1("mis_no_ren", mem_ren, 1'b0); check1("mis_err_not_yet", fetch_err, 1'b0); tick();
        sample(); check1("mis_err", fetch_err, 1'b1); check32("mis_instr", instr, NOP_W); tick();
        cyc(3);
        nRST = 1'b0; mem_ack = 1'b0;
        sample(); check1("mis_err_rst", fetch_err, 1'b0); tick();

        // TIMEOUT=4 instance: four REQ cycles then ERR, late ack ignored
        PCaddr = 32'h20; nRST4 = 1'b1;
        sample(); check1("t4_c1_no_ren", mem_ren4, 1'b0); tick();
        for (int i = 2; i <= 5; i++) begin
            sample();
            check1("t4_req_ren", mem_ren4, 1'b1); check32("t4_req_addr", mem_addr4, 32'h20);
            check1("t4_req_no_err", fetch_err4, 1'b0);
            tick();
        end
        mem_ack = 1'b1;
        sample();
        check1("t4_c6_err", fetch_err4, 1'b1); check1("t4_c6_ren", mem_ren4, 1'b0);
        check1("t4_c6_iready", iready4, 1'b0); check32("t4_c6_instr", instr4, NOP_W);
        tick();
        mem_ack = 1'b0;
        sample(); check1("t4_c7_err", fetch_err4, 1'b1); check32("t4_count", instr_count4, 32'h0); tick();
        nRST4 = 1'b0;
        sample(); check1("t4_rst_err", fetch_err4, 1'b0); tick();

        // Reset mid-request, ack during IDLE ignored, count wrap
        PCaddr = 32'h30; mem_rdata = 32'h0010_0073; nRST = 1'b1;
        sample(); tick();
        sample(); check1("r42_ren", mem_ren, 1'b1); tick();
        sample(); tick();
        nRST = 1'b0;
        sample(); check1("r42_rst_ren", mem_ren, 1'b0); check32("r42_rst_addr", mem_addr, 32'h0); tick();
        nRST = 1'b1; mem_ack = 1'b1;
        sample();
        check32("r42_idle_instr", instr, NOP_W); check1("r42_idle_iready", iready, 1'b0);
        check1("r42_idle_ren", mem_ren, 1'b0);
        tick();
        mem_ack = 1'b0;
        sample(); check1("r42_fresh_ren", mem_ren, 1'b1); check32("r42_fresh_addr", mem_addr, 32'h30); tick();
        mem_ack = 1'b1;
        sample(); tick();
        mem_ack = 1'b0; stall = 1'b1;
        sample(); tick();
        force u_dut.count_q = 32'hFFFF_FFFF;
        force_active = 1'b1;
        sample(); check32("r42_forced", instr_count, 32'hFFFF_FFFF); tick();
        release u_dut.count_q;
        force_active = 1'b0;
        sample(); check32("r42_preload_kept", instr_count, 32'hFFFF_FFFF); tick();
        stall = 1'b0;
        sample(); check1("r42_iready", iready, 1'b1); check32("r42_instr", instr, 32'h0010_0073); tick();
        sample(); check32("r42_wrap", instr_count, 32'h0); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum REQ-state cycles without mem_ack before error.
REQ-002 Parameter NOP, default 32'h0000_0013: instruction presented when no valid fetch is held.
REQ-003 clk  in  1  system clock; all state changes on rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 PCaddr  in  32  current PC from the pc stage.
REQ-006 stall  in  1  downstream busy (data-memory access); holds the current instruction.
REQ-007 mem_ack  in  1  instruction memory read complete; mem_rdata valid this cycle.
REQ-008 mem_rdata  in  32  instruction word from memory.
REQ-009 mem_ren  out  1  read request to instruction memory.
REQ-010 mem_addr  out  32  read address.
REQ-011 instr  out  32  instruction to decode/control unit.
REQ-012 iready  out  1  one-cycle pulse; pc stage advances on this edge.
REQ-013 fetch_err  out  1  sticky fetch fault (misaligned PC or timeout).
REQ-014 instr_count  out  32  retired-fetch counter.

Function
REQ-015 FSM states IDLE, REQ, EXEC, ERR, with state register encoded per the shared enum.
REQ-016 IDLE: mem_ren=0, iready=0; unconditional transition to REQ on the next edge.
REQ-017 REQ with PCaddr[1:0]!=0: mem_ren=0; next state ERR.
REQ-018 REQ with PCaddr aligned: mem_ren=1, mem_addr=PCaddr (combinational; stable because iready=0).
REQ-019 REQ with mem_ack=1 (including first REQ cycle): latch mem_rdata into instruction register; next state EXEC.
REQ-020 REQ, no ack: timeout counter (8 bits min, sized from TIMEOUT) increments; at count==TIMEOUT-1 with no ack, next state ERR.
REQ-021 Timeout counter clears on every entry to REQ.
REQ-022 mem_ack outside REQ, or with mem_ren=0, is ignored.
REQ-023 EXEC, stall=1: iready=0, stay in EXEC, instruction register held.
REQ-024 EXEC, stall=0: iready=1 for exactly that cycle; next state REQ.
REQ-025 Minimum fetch-to-fetch period 2 cycles (REQ with immediate ack, EXEC); no back-to-back iready.
REQ-026 instr = instruction register in EXEC; NOP in every other state.
REQ-027 instr_count increments by 1 on each cycle with iready=1; wraps 32'hFFFF_FFFF -> 0.
REQ-028 ERR: absorbing until reset; fetch_err=1, mem_ren=0, iready=0, instr=NOP.
REQ-029 mem_addr = 0 in all states other than REQ.

Reset
REQ-030 nRST=0 forces immediately: state IDLE, instruction register=NOP, timeout counter=0, instr_count=0.
REQ-031 During reset: mem_ren=0, mem_addr=0, iready=0, instr=NOP, fetch_err=0.
REQ-032 Reset mid-request abandons the access; a late mem_ack after reset release is ignored because state is IDLE.
REQ-033 First mem_ren after reset release occurs in the second cycle (IDLE, then REQ).

Structure
REQ-034 Fetch state enum and the NOP constant live in the shared cpu package beside the cuOP opcode constants.
REQ-035 Single module; no sub-module. Timeout and instr_count are inline registers.
REQ-036 One always_ff (async-reset) for registers, one always_comb for next-state and outputs.

Verification
REQ-037 Reset release, PCaddr=0x0000_0000, mem_ack on the first REQ cycle with rdata=0x0050_0093 -> mem_ren high in cycle 2; instr=0x0050_0093 and iready=1 in cycle 3; instr_count=1.
REQ-038 mem_ack delayed 5 cycles -> mem_ren held 6 cycles, mem_addr constant, iready=0 throughout; single iready after ack.
REQ-039 EXEC with stall=1 for 3 cycles -> iready=0 and instr held 3 cycles; iready=1 in the cycle stall drops.
REQ-040 PCaddr=0x0000_0002 in REQ -> no mem_ren, fetch_err=1 next cycle, instr=NOP; remains until nRST=0, then fetch_err=0.
REQ-041 TIMEOUT=4, no ack -> exactly 4 REQ cycles, then ERR; ack asserted in cycle 6 ignored.
REQ-042 nRST pulsed low mid-REQ, ack arrives during IDLE -> ack ignored, fresh request issued; instr_count preloaded to 0xFFFF_FFFF (force) wraps to 0 on the next iready.
